// File: rtl/spdif_transmitter.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
//  Module   : spdif_transmitter
//  Purpose  : IEC 60958 consumer S/PDIF biphase-mark encoder for 16-bit
//             stereo PCM. It builds subframes with B/M/W preambles and
//             V/U/C/P bits, and tracks a 192-frame channel-status block.
//             Everything is paced by a half-cell enable running at 128 x Fs.
//  Ports    : Clk          - system clock
//             nReset       - asynchronous active-low reset
//             Clk_Ena      - one-Clk pulse per half-cell
//             Audio_Valid  - Audio_L/Audio_R hold a sample pair
//             Audio_Ready  - holding register empty (accepts a pair)
//             Audio_L/R    - 16-bit two's-complement samples
//             SPDIF        - registered biphase-mark line output
//             Frame_Start  - pulse with the first half-cell of each frame
//             Block_Start  - pulse with the first half-cell of frame 0
//             Underrun     - pulse when a frame starts with no sample pair
//  Config   : `define SPDIF_TX_CHANNEL_STATUS_EN to transmit the consumer
//             channel-status block. Otherwise C is 0 in every subframe.
//  Revision : 1.0 - initial release
// ============================================================================
module spdif_transmitter #(
   parameter int AUX_ZERO = 1
) (
   input  logic        Clk,
   input  logic        nReset,
   input  logic        Clk_Ena,
   input  logic        Audio_Valid,
   output logic        Audio_Ready,
   input  logic [15:0] Audio_L,
   input  logic [15:0] Audio_R,
   output logic        SPDIF,
   output logic        Frame_Start,
   output logic        Block_Start,
   output logic        Underrun
);

   // Preambles written for a preceding line level of 0. They are sent MSB first.
   localparam logic [7:0] c_pre_b      = 8'b1110_1000;
   localparam logic [7:0] c_pre_m      = 8'b1110_0010;
   localparam logic [7:0] c_pre_w      = 8'b1110_0100;
   localparam logic [7:0] c_last_frame = 8'd191;

   // Aux slots 4..11 are always driven 0, so no other packing is implemented.
   generate
      if (AUX_ZERO != 1) begin : g_aux_unsupported
         $error("spdif_transmitter: only AUX_ZERO = 1 is supported");
      end
   endgenerate

   logic [5:0]  hc_q, hc_d;
   logic        sf_q, sf_d;
   logic [7:0]  fr_q, fr_d;
   logic [15:0] hold_l_q, hold_l_d, hold_r_q, hold_r_d;
   logic        full_q, full_d;
   logic [15:0] tx_l_q, tx_l_d, tx_r_q, tx_r_d;
   logic        v_q, v_d;
   logic        spdif_q, spdif_d;
   logic        pre_lvl_q, pre_lvl_d;
   logic        frame_start_q, frame_start_d;
   logic        block_start_q, block_start_d;
   logic        underrun_q, underrun_d;

   logic        w_accept, w_frame_load, w_cs, w_cell_bit, w_parity;
   logic        w_pre_bit, w_level;
   logic [15:0] w_sample;
   logic [7:0]  w_pre;
   logic [4:0]  w_slot;

`ifdef SPDIF_TX_CHANNEL_STATUS_EN
   // Consumer block: bit 2 is copy permitted, and bits 24..27 = 0100 select 48 kHz.
   assign w_cs = (fr_q == 8'd2) || (fr_q == 8'd25);
`else
   assign w_cs = 1'b0;
`endif

   // Level of the half-cell that is emitted on this Clk_Ena.
   always_comb begin
      w_slot     = hc_q[5:1];
      w_sample   = sf_q ? tx_r_q : tx_l_q;
      w_parity   = ^{w_sample, v_q, w_cs};
      w_cell_bit = 1'b0;
      for (int i = 0; i < 16; i++) begin
         if (w_slot == 5'(i + 12)) begin
            w_cell_bit = w_sample[i];
         end
      end
      if (w_slot == 5'd28) begin
         w_cell_bit = v_q;
      end else if (w_slot == 5'd30) begin
         w_cell_bit = w_cs;
      end else if (w_slot == 5'd31) begin
         w_cell_bit = w_parity;
      end
      w_pre     = sf_q ? c_pre_w : ((fr_q == 8'd0) ? c_pre_b : c_pre_m);
      w_pre_bit = w_pre[3'd7 - hc_q[2:0]];
      // Preamble half-cells are taken relative to the level just before the
      // preamble. That level is latched at half-cell 0 for the remaining seven.
      if (hc_q[5:3] == 3'd0) begin
         w_level = w_pre_bit ^ ((hc_q == 6'd0) ? spdif_q : pre_lvl_q);
      end else if (!hc_q[0]) begin
         w_level = ~spdif_q;
      end else begin
         w_level = spdif_q ^ w_cell_bit;
      end
   end

   always_comb begin
      hc_d          = hc_q;
      sf_d          = sf_q;
      fr_d          = fr_q;
      hold_l_d      = hold_l_q;
      hold_r_d      = hold_r_q;
      full_d        = full_q;
      tx_l_d        = tx_l_q;
      tx_r_d        = tx_r_q;
      v_d           = v_q;
      spdif_d       = spdif_q;
      pre_lvl_d     = pre_lvl_q;
      frame_start_d = 1'b0;
      block_start_d = 1'b0;
      underrun_d    = 1'b0;

      w_accept     = Audio_Valid & ~full_q;
      w_frame_load = Clk_Ena & (hc_q == 6'd0) & ~sf_q;

      // A frame load and a handshake coincide only when the register is
      // empty. In that case the new pair waits for the next frame.
      if (w_accept) begin
         hold_l_d = Audio_L;
         hold_r_d = Audio_R;
         full_d   = 1'b1;
      end else if (w_frame_load) begin
         full_d = 1'b0;
      end

      if (w_frame_load) begin
         tx_l_d        = full_q ? hold_l_q : 16'd0;
         tx_r_d        = full_q ? hold_r_q : 16'd0;
         v_d           = ~full_q;
         frame_start_d = 1'b1;
         block_start_d = (fr_q == 8'd0);
         underrun_d    = ~full_q;
      end

      if (Clk_Ena) begin
         spdif_d = w_level;
         if (hc_q == 6'd0) begin
            pre_lvl_d = spdif_q;
         end
         if (hc_q == 6'd63) begin
            hc_d = 6'd0;
            sf_d = ~sf_q;
            if (sf_q) begin
               fr_d = (fr_q == c_last_frame) ? 8'd0 : fr_q + 8'd1;
            end
         end else begin
            hc_d = hc_q + 6'd1;
         end
      end
   end

   always_ff @(posedge Clk or negedge nReset) begin
      if (!nReset) begin
         hc_q          <= 6'd0;
         sf_q          <= 1'b0;
         fr_q          <= 8'd0;
         hold_l_q      <= 16'd0;
         hold_r_q      <= 16'd0;
         full_q        <= 1'b0;
         tx_l_q        <= 16'd0;
         tx_r_q        <= 16'd0;
         v_q           <= 1'b1;
         spdif_q       <= 1'b0;
         pre_lvl_q     <= 1'b0;
         frame_start_q <= 1'b0;
         block_start_q <= 1'b0;
         underrun_q    <= 1'b0;
      end else begin
         hc_q          <= hc_d;
         sf_q          <= sf_d;
         fr_q          <= fr_d;
         hold_l_q      <= hold_l_d;
         hold_r_q      <= hold_r_d;
         full_q        <= full_d;
         tx_l_q        <= tx_l_d;
         tx_r_q        <= tx_r_d;
         v_q           <= v_d;
         spdif_q       <= spdif_d;
         pre_lvl_q     <= pre_lvl_d;
         frame_start_q <= frame_start_d;
         block_start_q <= block_start_d;
         underrun_q    <= underrun_d;
      end
   end

   assign Audio_Ready = ~full_q;
   assign SPDIF       = spdif_q;
   assign Frame_Start = frame_start_q;
   assign Block_Start = block_start_q;
   assign Underrun    = underrun_q;

endmodule
`default_nettype wire

// File: tb/tb_spdif_transmitter.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
//  Module   : tb_spdif_transmitter
//  Purpose  : Self-checking bench for spdif_transmitter. A behavioural model
//             builds each 64-half-cell subframe from its bit list and checks
//             the line, the pulses and Audio_Ready on every step.
//  Revision : 1.0 - initial release
// ============================================================================
module tb_spdif_transmitter;

   logic        Clk = 1'b0;
   logic        nReset;
   logic        Clk_Ena;
   logic        Audio_Valid;
   logic        Audio_Ready;
   logic [15:0] Audio_L;
   logic [15:0] Audio_R;
   logic        SPDIF;
   logic        Frame_Start;
   logic        Block_Start;
   logic        Underrun;

   spdif_transmitter #(.AUX_ZERO(1)) dut (
      .Clk         (Clk),
      .nReset      (nReset),
      .Clk_Ena     (Clk_Ena),
      .Audio_Valid (Audio_Valid),
      .Audio_Ready (Audio_Ready),
      .Audio_L     (Audio_L),
      .Audio_R     (Audio_R),
      .SPDIF       (SPDIF),
      .Frame_Start (Frame_Start),
      .Block_Start (Block_Start),
      .Underrun    (Underrun)
   );

   always #10 Clk = ~Clk;

   int checks = 0;
   int passed = 0;

   // Reference model state.
   int          hc_m, sf_m, fr_m;
   bit          m_full, m_v, m_line;
   logic [15:0] m_hl, m_hr, m_tl, m_tr;
   bit          exp_sub [64];
   bit          rec [64];
   int          last_hc, last_sf, last_fr;
   int          ur_count, bs_count, fs_count;

   function automatic bit cs_exp(input int f);
`ifdef SPDIF_TX_CHANNEL_STATUS_EN
      return (f == 2) || (f == 25);
`else
      return 1'b0;
`endif
   endfunction

   function automatic bit dec(input int s);
      return rec[2*s] ^ rec[2*s+1];
   endfunction

   task automatic model_reset();
      hc_m = 0; sf_m = 0; fr_m = 0;
      m_full = 1'b0; m_v = 1'b1; m_line = 1'b0;
      m_hl = '0; m_hr = '0; m_tl = '0; m_tr = '0;
      ur_count = 0; bs_count = 0; fs_count = 0;
      last_hc = -1; last_sf = -1; last_fr = -1;
   endtask

   // Build the 64 half-cells of the subframe that starts now. The subframe is
   // described as a list of 32 slot bits and then biphase-mark encoded.
   task automatic build_subframe();
      logic [7:0]  pre;
      logic [15:0] smp;
      bit          b [32];
      int          ones;
      bit          lvl;
      pre = (sf_m == 1) ? 8'b11100100 : ((fr_m == 0) ? 8'b11101000 : 8'b11100010);
      smp = (sf_m == 1) ? m_tr : m_tl;
      for (int s = 0; s < 32; s++) b[s] = 1'b0;
      for (int i = 0; i < 16; i++) b[12+i] = smp[i];
      b[28] = m_v;
      b[30] = cs_exp(fr_m);
      ones = 0;
      for (int s = 4; s < 31; s++) ones += int'(b[s]);
      b[31] = ((ones % 2) == 1);
      for (int i = 0; i < 8; i++) exp_sub[i] = pre[7-i] ^ m_line;
      lvl = exp_sub[7];
      for (int s = 4; s < 32; s++) begin
         lvl = ~lvl;
         exp_sub[2*s] = lvl;
         if (b[s]) lvl = ~lvl;
         exp_sub[2*s+1] = lvl;
      end
   endtask

   // One Clk cycle: drive the inputs, advance the model, then compare all outputs.
   task automatic step(input bit ena, input bit offer, input logic [15:0] l, input logic [15:0] r);
      bit e_fs, e_bs, e_ur, acc;
      e_fs = 1'b0; e_bs = 1'b0; e_ur = 1'b0;
      Clk_Ena = ena; Audio_Valid = offer; Audio_L = l; Audio_R = r;
      checks++;
      if (Audio_Ready !== !m_full) $display("FAIL ready: got %b expected %b", Audio_Ready, !m_full);
      else passed++;
      acc = offer && !m_full;
      if (ena) begin
         if (hc_m == 0) begin
            if (sf_m == 0) begin
               e_fs = 1'b1;
               e_bs = (fr_m == 0);
               if (m_full) begin
                  m_tl = m_hl; m_tr = m_hr; m_v = 1'b0; m_full = 1'b0;
               end else begin
                  m_tl = '0; m_tr = '0; m_v = 1'b1; e_ur = 1'b1;
               end
            end
            build_subframe();
         end
         m_line  = exp_sub[hc_m];
         last_hc = hc_m; last_sf = sf_m; last_fr = fr_m;
         if (hc_m == 63) begin
            hc_m = 0;
            if (sf_m == 1) begin
               sf_m = 0;
               fr_m = (fr_m == 191) ? 0 : fr_m + 1;
            end else sf_m = 1;
         end else hc_m++;
      end
      if (acc) begin
         m_full = 1'b1; m_hl = l; m_hr = r;
      end
      @(posedge Clk);
      @(negedge Clk);
      checks++;
      if (SPDIF !== m_line) $display("FAIL spdif fr%0d sf%0d hc%0d: got %b expected %b", last_fr, last_sf, last_hc, SPDIF, m_line);
      else passed++;
      checks++;
      if (Frame_Start !== e_fs) $display("FAIL frame_start: got %b expected %b", Frame_Start, e_fs);
      else passed++;
      checks++;
      if (Block_Start !== e_bs) $display("FAIL block_start: got %b expected %b", Block_Start, e_bs);
      else passed++;
      checks++;
      if (Underrun !== e_ur) $display("FAIL underrun: got %b expected %b", Underrun, e_ur);
      else passed++;
      if (ena) rec[last_hc] = SPDIF;
      if (Underrun === 1'b1) ur_count++;
      if (Block_Start === 1'b1) bs_count++;
      if (Frame_Start === 1'b1) fs_count++;
      Clk_Ena = 1'b0; Audio_Valid = 1'b0;
   endtask

   task automatic do_reset();
      @(negedge Clk);
      nReset = 1'b0;
      @(negedge Clk);
      @(negedge Clk);
      nReset = 1'b1;
      model_reset();
   endtask

   task automatic test_reset();
      logic [7:0] got;
      @(negedge Clk);
      checks++; if (SPDIF !== 1'b0) $display("FAIL reset_spdif: got %b expected 0", SPDIF); else passed++;
      checks++; if (Audio_Ready !== 1'b1) $display("FAIL reset_ready: got %b expected 1", Audio_Ready); else passed++;
      checks++; if (Frame_Start !== 1'b0) $display("FAIL reset_fs: got %b expected 0", Frame_Start); else passed++;
      checks++; if ({Block_Start, Underrun} !== 2'b00) $display("FAIL reset_bs_ur: got %b expected 00", {Block_Start, Underrun}); else passed++;
      nReset = 1'b1;
      model_reset();
      for (int n = 0; n < 128; n++) begin
         step(1'b1, 1'b0, 16'h0, 16'h0);
         if (last_hc == 7 && last_sf == 0) begin
            for (int i = 0; i < 8; i++) got[7-i] = rec[i];
            checks++;
            if (got !== 8'b11101000) $display("FAIL first_preamble: got %b expected 11101000", got);
            else passed++;
         end
         if (last_hc == 63) begin
            checks++;
            if (dec(28) !== 1'b1) $display("FAIL underrun_v sf%0d: got %b expected 1", last_sf, dec(28));
            else passed++;
         end
      end
      checks++; if (ur_count != 1) $display("FAIL underrun_count: got %0d expected 1", ur_count); else passed++;
      checks++; if (bs_count != 1) $display("FAIL block_start_count: got %0d expected 1", bs_count); else passed++;
   endtask

   task automatic test_stream();
      int ones;
      ur_count = 0;
      step(1'b0, 1'b1, 16'h0001, 16'h8000);
      for (int n = 0; n < 4 * 128; n++) begin
         step(1'b1, 1'b1, 16'h0001, 16'h8000);
         if (last_hc == 63) begin
            checks++;
            if (last_sf == 0 && dec(12) !== 1'b1) $display("FAIL left_slot12: got %b expected 1", dec(12));
            else if (last_sf == 1 && dec(27) !== 1'b1) $display("FAIL right_slot27: got %b expected 1", dec(27));
            else passed++;
         end
      end
      for (int n = 0; n < 6 * 128; ) begin
         bit ena;
         ena = ($urandom_range(0, 3) != 0);
         step(ena, 1'b1, 16'($urandom), 16'($urandom));
         if (ena) begin
            n++;
            if (last_hc == 63) begin
               ones = 0;
               for (int s = 4; s < 32; s++) ones += int'(dec(s));
               checks++;
               if ((ones % 2) != 0) $display("FAIL parity fr%0d sf%0d: got %0d ones expected even", last_fr, last_sf, ones);
               else passed++;
            end
         end
      end
      checks++; if (ur_count != 0) $display("FAIL stream_underrun: got %0d expected 0", ur_count); else passed++;
   endtask

   task automatic test_full_block();
      int         k;
      bit         plvl;
      logic [7:0] got, exp;
      bit         c_l [192];
      bit         c_r [192];
      do_reset();
      k = 0;
      plvl = 1'b0;
      for (int n = 0; n < 192 * 128 + 8; n++) begin
         if (hc_m == 0) plvl = SPDIF;
         step(1'b1, ($urandom_range(0, 1) == 1), 16'($urandom), 16'($urandom));
         if (last_hc == 7) begin
            for (int i = 0; i < 8; i++) got[7-i] = rec[i] ^ plvl;
            if (k == 0 || k == 384) exp = 8'b11101000;
            else if ((k % 2) == 1) exp = 8'b11100100;
            else exp = 8'b11100010;
            checks++;
            if ({plvl, got} !== {1'b0, exp}) $display("FAIL preamble_seq %0d: got lvl %b pat %b expected lvl 0 pat %b", k, plvl, got, exp);
            else passed++;
            k++;
         end
         if (last_hc == 63) begin
            if (last_sf == 0) c_l[last_fr] = dec(30);
            else c_r[last_fr] = dec(30);
         end
      end
      for (int f = 0; f < 192; f++) begin
         checks++;
         if (c_l[f] !== cs_exp(f) || c_r[f] !== cs_exp(f))
            $display("FAIL c_bit %0d: got L%b R%b expected %b", f, c_l[f], c_r[f], cs_exp(f));
         else passed++;
      end
      checks++; if (bs_count != 2) $display("FAIL block_count: got %0d expected 2", bs_count); else passed++;
   endtask

   task automatic test_late_offer();
      int          guard, fcount;
      logic [15:0] l, r, got_l, got_r;
      guard = 0;
      step(1'b1, 1'b0, 16'h0, 16'h0);
      while (!(hc_m == 0 && sf_m == 0 && !m_full) && guard < 400) begin
         step(1'b1, 1'b0, 16'h0, 16'h0);
         guard++;
      end
      checks++;
      if (guard >= 400) $display("FAIL late_offer_align: got timeout expected frame boundary");
      else passed++;
      l = 16'($urandom); r = 16'($urandom);
      step(1'b1, 1'b1, l, r);
      checks++; if (Underrun !== 1'b1) $display("FAIL late_offer_underrun: got %b expected 1", Underrun); else passed++;
      fcount = 0;
      for (int n = 0; n < 255; n++) begin
         step(1'b1, 1'b0, 16'h0, 16'h0);
         if (Frame_Start === 1'b1) fcount++;
         if (fcount == 1 && last_hc == 63) begin
            for (int i = 0; i < 16; i++) begin
               if (last_sf == 0) got_l[i] = dec(12 + i);
               else got_r[i] = dec(12 + i);
            end
            checks++;
            if (last_sf == 0 && {dec(28), got_l} !== {1'b0, l}) $display("FAIL late_left: got v%b %h expected v0 %h", dec(28), got_l, l);
            else if (last_sf == 1 && {dec(28), got_r} !== {1'b0, r}) $display("FAIL late_right: got v%b %h expected v0 %h", dec(28), got_r, r);
            else passed++;
         end
      end
   endtask

   task automatic test_reset_mid();
      int         guard;
      logic [7:0] got;
      do_reset();
      guard = 0;
      while (!(last_fr == 17 && last_sf == 0 && last_hc == 40) && guard < 20000) begin
         step(1'b1, ($urandom_range(0, 1) == 1), 16'($urandom), 16'($urandom));
         guard++;
      end
      checks++;
      if (guard >= 20000) $display("FAIL reset_mid_reach: got timeout expected frame 17");
      else passed++;
      // Try to load a sample so that Ready is low before the reset, when possible.
      Audio_Valid = 1'b1;
      #3 nReset = 1'b0;
      #1;
      checks++; if (SPDIF !== 1'b0) $display("FAIL reset_mid_spdif: got %b expected 0", SPDIF); else passed++;
      checks++; if (Audio_Ready !== 1'b1) $display("FAIL reset_mid_ready: got %b expected 1", Audio_Ready); else passed++;
      Clk_Ena = 1'b1;
      @(negedge Clk);
      @(negedge Clk);
      nReset = 1'b1;
      Clk_Ena = 1'b0; Audio_Valid = 1'b0;
      model_reset();
      for (int n = 0; n < 128; n++) begin
         step(1'b1, 1'b0, 16'h0, 16'h0);
         if (n == 0) begin
            checks++;
            if (Block_Start !== 1'b1) $display("FAIL reset_mid_block: got %b expected 1", Block_Start);
            else passed++;
         end
         if (n == 7) begin
            for (int i = 0; i < 8; i++) got[7-i] = rec[i];
            checks++;
            if (got !== 8'b11101000) $display("FAIL reset_mid_preamble: got %b expected 11101000", got);
            else passed++;
         end
      end
   endtask

   task automatic test_stall();
      int   guard;
      logic hold;
      guard = 0;
      while (hc_m != 20 && guard < 200) begin
         step(1'b1, 1'b0, 16'h0, 16'h0);
         guard++;
      end
      checks++;
      if (guard >= 200) $display("FAIL stall_align: got timeout expected hc 20");
      else passed++;
      hold = SPDIF;
      for (int n = 0; n < 1000; n++) step(1'b0, ($urandom_range(0, 7) == 0), 16'($urandom), 16'($urandom));
      checks++; if (SPDIF !== hold) $display("FAIL stall_hold: got %b expected %b", SPDIF, hold); else passed++;
      for (int n = 0; n < 300; n++) step(1'b1, ($urandom_range(0, 1) == 1), 16'($urandom), 16'($urandom));
   endtask

   initial begin
      nReset = 1'b0;
      Clk_Ena = 1'b0;
      Audio_Valid = 1'b0;
      Audio_L = 16'h0;
      Audio_R = 16'h0;
      model_reset();
      repeat (2) @(negedge Clk);
      test_reset();
      test_stream();
      test_full_block();
      test_late_offer();
      test_reset_mid();
      test_stall();
      $display("%0d/%0d checks passed", passed, checks);
      $finish;
   end

endmodule
`default_nettype wire
